// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared types and size encodings for the LSU data-memory bridge
package dmem_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } dmem_state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // Store requests encode size as 01/10/11; map onto the load size encoding.
   function automatic logic [1:0] store_size(input logic [1:0] we);
      case (we)
         2'b01:   store_size = SZ_B;
         2'b10:   store_size = SZ_H;
         default: store_size = SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// rtl/dmem_bridge_if.sv - request/grant/response data-memory bus
interface dmem_bridge_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-enable, write-lane replication and load shift from addr[1:0] and size
module dmem_lane_align
   import dmem_bridge_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] wr_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [4:0]  shift,
   output logic        misalign
);

   always_comb begin
      be       = 4'b1111;
      wdata    = wr_data;
      misalign = 1'b0;
      case (size)
         SZ_B: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{wr_data[7:0]}};
         end
         SZ_H: begin
            // Only addr[1] picks the half; an odd address wraps inside the word.
            be       = 4'b0011 << {addr_lo[1], 1'b0};
            wdata    = {2{wr_data[15:0]}};
            misalign = addr_lo[0];
         end
         default: begin
            misalign = (addr_lo != 2'b00);
         end
      endcase
      shift = {addr_lo, 3'b000};
   end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - LSU to variable-latency data-memory bridge; DMEM_MISALIGN_CHECK_EN rejects misaligned accesses
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int WAIT_MAX = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          d_re,
   input  logic [1:0]    d_ld_size,
   input  logic [1:0]    d_we,
   input  logic [31:0]   d_addr,
   input  logic [31:0]   d_wr_data,
   output logic [31:0]   d_rd_data,
   output logic          stall,
   output logic          d_timeout,
   output logic          d_misalign,
   dmem_bridge_if.master bus
);

   localparam int CW = $clog2(WAIT_MAX + 1);

   dmem_state_t   state, state_nxt;
   logic [CW-1:0] cnt;
   logic [4:0]    shift_r;

   logic          access, is_store, req_ok, timeout_hit;
   logic          issue, complete, expire;
   logic [1:0]    acc_size;
   logic [3:0]    la_be;
   logic [31:0]   la_wdata;
   logic [4:0]    la_shift;
   logic          la_misalign;

   assign is_store    = (d_we != 2'b00);
   assign access      = d_re | is_store;
   assign acc_size    = is_store ? store_size(d_we) : d_ld_size;
   assign timeout_hit = (cnt == CW'(WAIT_MAX - 1));

   dmem_lane_align u_lane_align (
      .addr_lo  (d_addr[1:0]),
      .size     (acc_size),
      .wr_data  (d_wr_data),
      .be       (la_be),
      .wdata    (la_wdata),
      .shift    (la_shift),
      .misalign (la_misalign)
   );

`ifdef DMEM_MISALIGN_CHECK_EN
   assign req_ok = access & ~la_misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_misalign <= 1'b0;
      else        d_misalign <= (state == IDLE) & access & la_misalign;
   end
`else
   logic unused_misalign;
   assign unused_misalign = la_misalign;
   assign req_ok          = access;
   assign d_misalign      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_ok) state_nxt = REQ;
         REQ: begin
            if (bus.bus_gnt & bus.bus_rvalid) state_nxt = IDLE;
            else if (timeout_hit)             state_nxt = IDLE;
            else if (bus.bus_gnt)             state_nxt = WAIT;
         end
         WAIT: if (bus.bus_rvalid | timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall       = 1'b0;
      bus.bus_req = 1'b0;
      issue       = 1'b0;
      complete    = 1'b0;
      case (state)
         IDLE: issue = req_ok;
         REQ: begin
            stall       = 1'b1;
            bus.bus_req = 1'b1;
            complete    = bus.bus_gnt & bus.bus_rvalid;
         end
         WAIT: begin
            stall    = 1'b1;
            complete = bus.bus_rvalid;
         end
         default: ;
      endcase
      // A response arriving in the last allowed cycle still completes.
      expire = (state != IDLE) & ~complete & timeout_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= 32'h0;
         bus.bus_be    <= 4'h0;
         bus.bus_wdata <= 32'h0;
         shift_r       <= 5'd0;
         cnt           <= '0;
         d_rd_data     <= 32'h0;
         d_timeout     <= 1'b0;
      end else begin
         if (issue) begin
            bus.bus_we    <= is_store;
            bus.bus_addr  <= {d_addr[31:2], 2'b00};
            bus.bus_be    <= la_be;
            bus.bus_wdata <= la_wdata;
            shift_r       <= la_shift;
            cnt           <= '0;
         end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
         end

         if (complete & ~bus.bus_we) d_rd_data <= bus.bus_rdata >> shift_r;
         else if (expire)            d_rd_data <= 32'h0;

         d_timeout <= expire;
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge with WAIT_MAX=8
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        d_re;
   logic [1:0]  d_ld_size;
   logic [1:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wr_data;
   logic [31:0] d_rd_data;
   logic        stall, d_timeout, d_misalign;

   int n_tests = 0;
   int n_fail  = 0;
   int stall_cycles;
   int req_cycles;

   dmem_bridge_if bus ();

   dmem_bridge #(.WAIT_MAX(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_re       (d_re),
      .d_ld_size  (d_ld_size),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wr_data  (d_wr_data),
      .d_rd_data  (d_rd_data),
      .stall      (stall),
      .d_timeout  (d_timeout),
      .d_misalign (d_misalign),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue_load(input logic [31:0] a, input logic [1:0] sz);
      d_re      = 1'b1;
      d_ld_size = sz;
      d_addr    = a;
      tick();
      d_re      = 1'b0;
   endtask

   task automatic issue_store(input logic [31:0] a, input logic [1:0] we, input logic [31:0] data);
      d_we      = we;
      d_addr    = a;
      d_wr_data = data;
      tick();
      d_we      = 2'b00;
   endtask

   task automatic respond_now(input logic [31:0] rdata);
      bus.bus_gnt    = 1'b1;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = rdata;
      tick();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      d_re           = 1'b0;
      d_ld_size      = 2'b00;
      d_we           = 2'b00;
      d_addr         = 32'h0;
      d_wr_data      = 32'h0;
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b0;
      bus.bus_rdata  = 32'h0;
      tick();
      tick();

      check("rst_stall", stall, 0);
      check("rst_req", bus.bus_req, 0);
      check("rst_be", bus.bus_be, 4'h0);
      check("rst_addr", bus.bus_addr, 32'h0);
      check("rst_rd_data", d_rd_data, 32'h0);
      check("rst_timeout", d_timeout, 0);
      check("rst_misalign", d_misalign, 0);
      rst_n = 1'b1;
      tick();

      // LW 0x100, zero-wait bus
      d_re = 1'b1; d_ld_size = 2'b10; d_addr = 32'h100;
      check("lw_issue_stall", stall, 0);
      tick();
      d_re = 1'b0;
      check("lw_req", bus.bus_req, 1);
      check("lw_stall", stall, 1);
      check("lw_be", bus.bus_be, 4'b1111);
      check("lw_addr", bus.bus_addr, 32'h100);
      check("lw_we", bus.bus_we, 0);
      respond_now(32'hCAFEBABE);
      check("lw_stall_done", stall, 0);
      check("lw_data", d_rd_data, 32'hCAFEBABE);

      // LB 0x103
      issue_load(32'h103, 2'b00);
      check("lb_be", bus.bus_be, 4'b1000);
      respond_now(32'h80112233);
      check("lb_data", d_rd_data, 32'h00000080);

      // LH 0x102
      issue_load(32'h102, 2'b01);
      check("lh_be", bus.bus_be, 4'b1100);
      respond_now(32'hBEEF1234);
      check("lh_data", d_rd_data, 32'h0000BEEF);

      // SB 0x101
      issue_store(32'h101, 2'b01, 32'h000000AB);
      check("sb_be", bus.bus_be, 4'b0010);
      check("sb_wdata", bus.bus_wdata, 32'hABABABAB);
      respond_now(32'hFFFFFFFF);
      check("sb_no_data_update", d_rd_data, 32'h0000BEEF);

      // SH 0x202: gnt on the 4th REQ cycle, rvalid 2 cycles after that
      issue_store(32'h202, 2'b10, 32'h0000BEEF);
      stall_cycles = 0;
      for (int c = 1; c <= 20; c++) begin
         if (!stall) break;
         stall_cycles++;
         if (c == 1) begin
            check("sh_be", bus.bus_be, 4'b1100);
            check("sh_wdata", bus.bus_wdata, 32'hBEEFBEEF);
            check("sh_we", bus.bus_we, 1);
            check("sh_addr", bus.bus_addr, 32'h200);
         end
         if (c == 4) check("sh_wdata_stable", bus.bus_wdata, 32'hBEEFBEEF);
         if (c == 5) check("sh_wait_req_low", bus.bus_req, 0);
         bus.bus_gnt    = (c == 4);
         bus.bus_rvalid = (c == 6);
         tick();
      end
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b0;
      check("sh_stall_cycles", stall_cycles, 6);
      check("sh_rd_data_kept", d_rd_data, 32'h0000BEEF);

      // Timeout: no grant ever
      issue_load(32'h300, 2'b10);
      req_cycles = 0;
      for (int c = 1; c <= 20; c++) begin
         if (!bus.bus_req) break;
         req_cycles++;
         tick();
      end
      check("to_req_cycles", req_cycles, 8);
      check("to_pulse", d_timeout, 1);
      check("to_rd_data", d_rd_data, 32'h0);
      check("to_stall", stall, 0);
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'h12345678;
      tick();
      bus.bus_rvalid = 1'b0;
      check("to_pulse_end", d_timeout, 0);
      check("to_stale_ignored", d_rd_data, 32'h0);
      check("to_stale_stall", stall, 0);

      // Reset while in WAIT
      issue_load(32'h104, 2'b10);
      respond_now(32'hA5A5A5A5);
      check("pre_rst_data", d_rd_data, 32'hA5A5A5A5);
      issue_load(32'h108, 2'b10);
      bus.bus_gnt = 1'b1;
      tick();
      bus.bus_gnt = 1'b0;
      check("wait_stall", stall, 1);
      rst_n = 1'b0;
      #1;
      check("arst_stall", stall, 0);
      check("arst_req", bus.bus_req, 0);
      check("arst_rd_data", d_rd_data, 32'h0);
      tick();
      rst_n          = 1'b1;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'hDEADBEEF;
      tick();
      bus.bus_rvalid = 1'b0;
      check("post_rst_stale", d_rd_data, 32'h0);
      check("post_rst_stall", stall, 0);

      // LW 0x101 (misaligned word)
      d_re = 1'b1; d_ld_size = 2'b10; d_addr = 32'h101;
      tick();
      d_re = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      check("mis_pulse", d_misalign, 1);
      check("mis_no_req", bus.bus_req, 0);
      check("mis_stall", stall, 0);
      check("mis_rd_data", d_rd_data, 32'h0);
      tick();
      check("mis_pulse_end", d_misalign, 0);
      check("mis_no_req_after", bus.bus_req, 0);
`else
      check("mis_req", bus.bus_req, 1);
      check("mis_be", bus.bus_be, 4'b1111);
      check("mis_addr", bus.bus_addr, 32'h100);
      check("mis_tied", d_misalign, 0);
      respond_now(32'h11223344);
      check("mis_wrap_data", d_rd_data, 32'h00112233);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
